wave_gen: RTL
=============

Name: wave_gen

Overview:
Parametrised successor to the single-mode triangle counter. It produces a periodic ramp between programmable lower and upper bounds with a programmable step. Four run-time modes are supported: triangle, sawtooth-up, sawtooth-down and square. It feeds the Parzen-window kernel and address generators as a shape and sweep source, and flags extrema with one-cycle pulses.

Parameters:
W, 10, width of val_o, lo_i, hi_i and the internal counter.
STEP_W, 4, width of step_i.
RST_VAL, 0, value of val_o in reset and in IDLE before the first load.

Ports:
clk_i  in  1  clock; all logic on posedge.
rst_i  in  1  synchronous, active-high reset.
en_i  in  1  advance enable; low = hold current value and state.
cfg_load_i  in  1  one-cycle pulse; samples mode_i, lo_i, hi_i, step_i.
mode_i  in  2  0=TRI, 1=SAW_UP, 2=SAW_DN, 3=SQUARE.
lo_i  in  W  lower bound (unsigned).
hi_i  in  W  upper bound (unsigned).
step_i  in  STEP_W  increment per enabled cycle; 0 is treated as 1.
val_o  out  W  current waveform value (registered).
dir_up_o  out  1  1 while the internal ramp is rising.
peak_o  out  1  one-cycle pulse in the cycle the internal ramp equals hi.
trough_o  out  1  one-cycle pulse in the cycle the internal ramp equals lo (excluding the cycle right after load).
cfg_err_o  out  1  sticky until next load; set when the loaded lo >= hi.

Behaviour:
- Reset (rst_i=1, synchronous): val_o=RST_VAL, internal ramp=RST_VAL, state IDLE, dir_up_o=0, peak_o=0, trough_o=0, cfg_err_o=0, cfg regs=0.
- States: IDLE, UP, DOWN, ERR.
- Load precedence: cfg_load_i overrides en_i and the current state, and is accepted in any state.
- Load effect: the cycle after cfg_load_i, the cfg regs hold the new values.
  - SAW_DN: ramp=hi, state DOWN.
  - All other modes: ramp=lo, state UP.
  - If lo >= hi: state ERR, ramp=lo, cfg_err_o=1.
- en_i=0: ramp, val_o and state hold; peak_o and trough_o drive 0.
- Arithmetic: compute ramp+step and ramp-step in W+1 bits so there is no wrap-around. Overshoot always saturates to the bound.
- UP, en=1: if ramp+step >= hi, ramp<=hi, else ramp<=ramp+step. On reaching hi:
  - TRI/SQUARE: next state DOWN.
  - SAW_UP: stay UP; the next enabled cycle ramp<=lo.
- DOWN, en=1: if ramp-step <= lo (signed compare in W+1 bits), ramp<=lo, else ramp<=ramp-step. On reaching lo:
  - TRI/SQUARE: next state UP.
  - SAW_DN: stay DOWN; the next enabled cycle ramp<=hi.
- Pulses: peak_o=1 in exactly the cycles where registered ramp==hi. trough_o=1 in exactly the cycles where registered ramp==lo, excluding the first cycle after a load. The wrap cycle of a sawtooth pulses the bound it lands on.
- val_o:
  - TRI/SAW modes: val_o=ramp.
  - SQUARE: val_o = hi while state UP, lo while state DOWN. The level switches in the cycle after peak/trough.
- dir_up_o: 1 when state==UP.
- ERR: val_o=lo, no pulses, ignores en_i; left only by load or reset.
- IDLE: val_o=RST_VAL, no pulses; left only by load.
- Reset mid-run: takes effect on the next edge irrespective of en_i or cfg_load_i.
- Latency: cfg to first value 1 cycle; each en_i=1 cycle produces exactly one step.

Decomposition:
- Package wave_gen_pkg holds:
  - typedef enum logic[1:0] mode_e {TRI, SAW_UP, SAW_DN, SQUARE};
  - typedef enum logic[1:0] state_e {IDLE, UP, DOWN, ERR};
  - mode code constants.
- One natural sub-module: wave_sat_step, a combinational saturating add/sub of ramp±step clamped to [lo,hi] with a reached-bound flag, instantiated once.
- FSM and output registers stay in wave_gen.

Test Plan:
- Reset: W=8, reset held 3 cycles with en_i=1 -> val_o=0, all flags 0, state IDLE; en_i alone never moves val_o.
- TRI: lo=10, hi=20, step=3, en=1 -> val_o 10,13,16,19,20,17,14,11,10,13; peak_o at 20, trough_o at the second 10 only.
- SAW_UP: lo=0, hi=7, step=2 -> 0,2,4,6,7,0,2; peak_o at 7, trough_o at the wrap 0. SAW_DN: lo=0, hi=7, step=2 -> 7,5,3,1,0,7.
- SQUARE plus enable gaps: lo=5, hi=9, step=0 (treated as 1), en toggled 1,0,1,... -> ramp advances only on en=1 cycles, val_o=9 while rising and 5 while falling, pulses 0 on en=0 cycles.
- Reload: TRI mid-descent (val=17), then load lo=100, hi=50 -> next cycle cfg_err_o=1, val_o=100, en ignored. A further load of lo=1, hi=4 -> cfg_err_o=0, val_o=1.
- Load plus reset: cfg_load_i and rst_i in the same cycle -> reset state wins; a load together with en_i=1 -> new lo and no step that cycle.

Source files
------------

// File: rtl/wave_gen_pkg.sv
// Shared mode/state encodings for the wave_gen ramp/shape generator.
package wave_gen_pkg;

  localparam int unsigned MODE_W = 2;

  localparam logic [MODE_W-1:0] MODE_TRI    = 2'd0;
  localparam logic [MODE_W-1:0] MODE_SAW_UP = 2'd1;
  localparam logic [MODE_W-1:0] MODE_SAW_DN = 2'd2;
  localparam logic [MODE_W-1:0] MODE_SQUARE = 2'd3;

  typedef enum logic [MODE_W-1:0] {
    TRI    = MODE_TRI,
    SAW_UP = MODE_SAW_UP,
    SAW_DN = MODE_SAW_DN,
    SQUARE = MODE_SQUARE
  } mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2,
    ERR  = 2'd3
  } state_e;

endpackage

// File: rtl/wave_sat_step.sv
// Saturating ramp +/- step, clamped to the active bound; hit_c_o flags landing on it.
module wave_sat_step #(
  parameter int unsigned W      = 10,
  parameter int unsigned STEP_W = 4
) (
  input  logic [W-1:0]      ramp_i,
  input  logic [W-1:0]      lo_i,
  input  logic [W-1:0]      hi_i,
  input  logic [STEP_W-1:0] step_i,
  input  logic              up_i,
  output logic [W-1:0]      next_c_o,
  output logic              hit_c_o
);

  localparam int unsigned XW = W + 1;

  logic        [W:0] w_sum;
  logic signed [W:0] w_diff;
  logic signed [W:0] w_lo_x;

  // One extra bit keeps both directions free of wrap-around.
  assign w_sum  = XW'(ramp_i) + XW'(step_i);
  assign w_diff = $signed(XW'(ramp_i)) - $signed(XW'(step_i));
  assign w_lo_x = $signed(XW'(lo_i));

  always_comb begin
    next_c_o = ramp_i;
    hit_c_o  = 1'b0;
    if (up_i) begin
      if (w_sum >= XW'(hi_i)) begin
        next_c_o = hi_i;
        hit_c_o  = 1'b1;
      end else begin
        next_c_o = W'(w_sum);
      end
    end else begin
      if (w_diff <= w_lo_x) begin
        next_c_o = lo_i;
        hit_c_o  = 1'b1;
      end else begin
        next_c_o = W'(w_diff);
      end
    end
  end

endmodule

// File: rtl/wave_gen.sv
// Programmable triangle / sawtooth / square ramp generator with extrema pulses.
module wave_gen
  import wave_gen_pkg::*;
#(
  parameter int unsigned   W       = 10,
  parameter int unsigned   STEP_W  = 4,
  parameter logic [W-1:0]  RST_VAL = '0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic              cfg_load_i,
  input  logic [1:0]        mode_i,
  input  logic [W-1:0]      lo_i,
  input  logic [W-1:0]      hi_i,
  input  logic [STEP_W-1:0] step_i,
  output logic [W-1:0]      val_o,
  output logic              dir_up_o,
  output logic              peak_o,
  output logic              trough_o,
  output logic              cfg_err_o
);

  state_e              r_state, w_state_nxt;
  mode_e               r_mode, w_mode_nxt;
  logic [W-1:0]        r_lo, w_lo_nxt;
  logic [W-1:0]        r_hi, w_hi_nxt;
  logic [STEP_W-1:0]   r_step, w_step_nxt;
  logic [W-1:0]        r_ramp, w_ramp_nxt;
  logic [W-1:0]        r_val, w_val_nxt;
  logic                r_peak, w_peak_nxt;
  logic                r_trough, w_trough_nxt;
  logic                r_dir_up, w_dir_nxt;
  logic                r_cfg_err, w_err_nxt;

  logic [STEP_W-1:0]   w_step_eff;
  logic [W-1:0]        w_sat_next;
  logic                w_sat_hit;

  assign w_step_eff = (r_step == '0) ? STEP_W'(1) : r_step;

  wave_sat_step #(.W(W), .STEP_W(STEP_W)) u_sat (
    .ramp_i   (r_ramp),
    .lo_i     (r_lo),
    .hi_i     (r_hi),
    .step_i   (w_step_eff),
    .up_i     (r_state == UP),
    .next_c_o (w_sat_next),
    .hit_c_o  (w_sat_hit)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= IDLE;
      r_mode    <= TRI;
      r_lo      <= '0;
      r_hi      <= '0;
      r_step    <= '0;
      r_ramp    <= RST_VAL;
      r_val     <= RST_VAL;
      r_peak    <= 1'b0;
      r_trough  <= 1'b0;
      r_dir_up  <= 1'b0;
      r_cfg_err <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_mode    <= w_mode_nxt;
      r_lo      <= w_lo_nxt;
      r_hi      <= w_hi_nxt;
      r_step    <= w_step_nxt;
      r_ramp    <= w_ramp_nxt;
      r_val     <= w_val_nxt;
      r_peak    <= w_peak_nxt;
      r_trough  <= w_trough_nxt;
      r_dir_up  <= w_dir_nxt;
      r_cfg_err <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_mode_nxt   = r_mode;
    w_lo_nxt     = r_lo;
    w_hi_nxt     = r_hi;
    w_step_nxt   = r_step;
    w_ramp_nxt   = r_ramp;
    w_val_nxt    = r_val;
    w_peak_nxt   = 1'b0;
    w_trough_nxt = 1'b0;

    if (cfg_load_i) begin
      w_mode_nxt = mode_e'(mode_i);
      w_lo_nxt   = lo_i;
      w_hi_nxt   = hi_i;
      w_step_nxt = step_i;
      if (lo_i >= hi_i) begin
        w_state_nxt = ERR;
        w_ramp_nxt  = lo_i;
        w_val_nxt   = lo_i;
      end else if (mode_e'(mode_i) == SAW_DN) begin
        w_state_nxt = DOWN;
        w_ramp_nxt  = hi_i;
        w_val_nxt   = hi_i;
        w_peak_nxt  = 1'b1;
      end else begin
        w_state_nxt = UP;
        w_ramp_nxt  = lo_i;
        w_val_nxt   = (mode_e'(mode_i) == SQUARE) ? hi_i : lo_i;
      end
    end else if (en_i && (r_state == UP || r_state == DOWN)) begin
      // Sawtooth wraps one enabled cycle after sitting on its far bound.
      if (r_state == UP) begin
        if (r_mode == SAW_UP && r_ramp == r_hi) begin
          w_ramp_nxt = r_lo;
        end else begin
          w_ramp_nxt = w_sat_next;
          if (w_sat_hit && r_mode != SAW_UP) w_state_nxt = DOWN;
        end
      end else begin
        if (r_mode == SAW_DN && r_ramp == r_lo) begin
          w_ramp_nxt = r_hi;
        end else begin
          w_ramp_nxt = w_sat_next;
          if (w_sat_hit && r_mode != SAW_DN) w_state_nxt = UP;
        end
      end
      w_peak_nxt   = (w_ramp_nxt == r_hi);
      w_trough_nxt = (w_ramp_nxt == r_lo);
      // Square level follows the direction held before this step, so it flips one cycle after an extremum.
      if (r_mode == SQUARE) w_val_nxt = (r_state == UP) ? r_hi : r_lo;
      else                  w_val_nxt = w_ramp_nxt;
    end

    w_dir_nxt = (w_state_nxt == UP);
    w_err_nxt = (w_state_nxt == ERR);
  end

  assign val_o     = r_val;
  assign dir_up_o  = r_dir_up;
  assign peak_o    = r_peak;
  assign trough_o  = r_trough;
  assign cfg_err_o = r_cfg_err;

endmodule
